// File: rtl/tdm_demux_1x8.sv
// TDM receive demux: rebuilds LANES parallel lanes from a framed sample stream.
// A shadow buffer collects one frame and publishes it to dout in a single update.
module tdm_demux_1x8 #(
    parameter int WIDTH = 8,
    parameter int LANES = 8,
    parameter int SELW  = $clog2(LANES)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [WIDTH-1:0]       din,
    input  logic                   din_valid,
    input  logic                   frame_sync,
    output logic [LANES*WIDTH-1:0] dout,
    output logic                   frame_valid,
    output logic [SELW-1:0]        lane_sel,
    output logic                   sync_err
);

    typedef enum logic {HUNT, RUN} state_t;

    state_t                          state_q, state_d;
    logic [SELW-1:0]                 lane_sel_q, lane_sel_d;
    logic [LANES-2:0][WIDTH-1:0]     shadow_q, shadow_d;
    logic [LANES*WIDTH-1:0]          dout_q, dout_d;
    logic                            frame_valid_q, frame_valid_d;
    logic                            sync_err_q, sync_err_d;

    logic last_lane;
    assign last_lane = (lane_sel_q == SELW'(LANES - 1));

    always_comb begin
        state_d       = state_q;
        lane_sel_d    = lane_sel_q;
        shadow_d      = shadow_q;
        dout_d        = dout_q;
        frame_valid_d = 1'b0;
        sync_err_d    = 1'b0;

        if (din_valid) begin
            unique case (state_q)
                HUNT: begin
                    if (frame_sync) begin
                        shadow_d[0] = din;
                        lane_sel_d  = SELW'(1);
                        state_d     = RUN;
                    end
                end
                RUN: begin
                    if (frame_sync) begin
                        // Early sync restarts the frame; stale lanes are
                        // overwritten before dout can be loaded again.
                        shadow_d[0] = din;
                        lane_sel_d  = SELW'(1);
                        sync_err_d  = (lane_sel_q != '0);
                    end else if (lane_sel_q == '0) begin
                        sync_err_d = 1'b1;
                        state_d    = HUNT;
                    end else begin
                        for (int i = 1; i < LANES - 1; i++) begin
                            if (lane_sel_q == SELW'(i)) begin
                                shadow_d[i] = din;
                            end
                        end
                        lane_sel_d = lane_sel_q + SELW'(1);
                        if (last_lane) begin
                            dout_d        = {din, shadow_q};
                            frame_valid_d = 1'b1;
                        end
                    end
                end
                default: state_d = HUNT;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= HUNT;
            lane_sel_q    <= '0;
            shadow_q      <= '0;
            dout_q        <= '0;
            frame_valid_q <= 1'b0;
            sync_err_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            lane_sel_q    <= lane_sel_d;
            shadow_q      <= shadow_d;
            dout_q        <= dout_d;
            frame_valid_q <= frame_valid_d;
            sync_err_q    <= sync_err_d;
        end
    end

    assign dout        = dout_q;
    assign frame_valid = frame_valid_q;
    assign lane_sel    = lane_sel_q;
    assign sync_err    = sync_err_q;

endmodule
